// File: rtl/audio_pkg.sv
// Shared audio-path types: frame geometry and the stereo pair carried from note playback to the DAC.
package audio_pkg;

    localparam int unsigned FRAME_BITS = 64;
    localparam int unsigned SLOT_BITS  = 32;
    localparam int unsigned BITCNT_W   = $clog2(FRAME_BITS);

    typedef struct packed {
        logic [SLOT_BITS-1:0] left;
        logic [SLOT_BITS-1:0] right;
    } stereo_pair_t;

    typedef enum logic [1:0] {
        PH_FRAME_START,
        PH_RIGHT_START,
        PH_SHIFT_LEFT,
        PH_SHIFT_RIGHT
    } slot_phase_e;

endpackage

// File: rtl/sample_fifo.sv
// Synchronous FIFO with combinational read of the head entry; clear beats push and pop.
module sample_fifo #(
    parameter int unsigned WIDTH = 64,
    parameter int unsigned DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     push,
    input  logic                     pop,
    input  logic                     clear,
    input  logic [WIDTH-1:0]         wr_data,
    output logic [WIDTH-1:0]         rd_data,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     full,
    output logic                     empty
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned CW = AW + 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic             do_push;
    logic             do_pop;

    assign full    = (count == CW'(DEPTH));
    assign empty   = (count == '0);
    assign do_push = push && !full && !clear;
    assign do_pop  = pop && !empty && !clear;
    assign rd_data = mem[rd_ptr];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else if (clear) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + AW'(1);
            if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
            unique case ({do_push, do_pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end

    // Storage needs no reset: entries are only read once the count covers them.
    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= wr_data;
    end

endmodule

// File: rtl/dac_serializer.sv
// Left-justified stereo DAC serializer: pair FIFO, BCLK/LRCK generation, MSB-first shifters.
module dac_serializer
    import audio_pkg::*;
#(
    parameter int unsigned SAMPLE_W   = 32,
    parameter int unsigned FIFO_DEPTH = 4,
    parameter int unsigned BCLK_HALF  = 16
) (
    input  logic                          CLOCK_50,
    input  logic                          resetn,
    input  logic [SAMPLE_W-1:0]           left_channel_audio_out,
    input  logic [SAMPLE_W-1:0]           right_channel_audio_out,
    input  logic                          write_audio_out,
    input  logic                          clear_audio_out_memory,
    output logic                          audio_out_allowed,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_count,
    output logic                          overflow,
    output logic                          underflow,
    output logic                          AUD_BCLK,
    output logic                          AUD_DACLRCK,
    output logic                          AUD_DACDAT
);

    localparam int unsigned DIV_W = $clog2(BCLK_HALF);

    logic [DIV_W-1:0]     div;
    logic [BITCNT_W-1:0]  bitcnt;
    logic [SLOT_BITS-1:0] left_sr;
    logic [SLOT_BITS-1:0] right_sr;

    stereo_pair_t wr_pair;
    stereo_pair_t rd_pair;
    stereo_pair_t load_pair;
    slot_phase_e  phase;
    logic         fifo_full;
    logic         fifo_empty;
    logic         tc_c;
    logic         fall_c;
    logic         frame_start_c;
    logic         push_c;
    logic         pop_c;
    logic         overflow_c;

    // Samples sit MSB-aligned in their slot so narrow samples trail with zeros.
    assign wr_pair.left  = SLOT_BITS'(left_channel_audio_out)  << (SLOT_BITS - SAMPLE_W);
    assign wr_pair.right = SLOT_BITS'(right_channel_audio_out) << (SLOT_BITS - SAMPLE_W);

    assign audio_out_allowed = !fifo_full;
    assign tc_c           = (div == DIV_W'(BCLK_HALF - 1));
    assign fall_c         = tc_c && AUD_BCLK;
    assign frame_start_c  = fall_c && (bitcnt == '0);
    assign push_c         = write_audio_out && audio_out_allowed && !clear_audio_out_memory;
    assign pop_c          = frame_start_c && !fifo_empty && !clear_audio_out_memory;
    assign overflow_c     = write_audio_out && fifo_full && !clear_audio_out_memory;

    sample_fifo #(
        .WIDTH ($bits(stereo_pair_t)),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk     (CLOCK_50),
        .rst_n   (resetn),
        .push    (push_c),
        .pop     (pop_c),
        .clear   (clear_audio_out_memory),
        .wr_data (wr_pair),
        .rd_data (rd_pair),
        .count   (fifo_count),
        .full    (fifo_full),
        .empty   (fifo_empty)
    );

    // Slot phase and frame-start payload (silence when nothing was popped).
    always_comb begin
        phase     = PH_SHIFT_LEFT;
        load_pair = '0;
        if (bitcnt == '0)                          phase = PH_FRAME_START;
        else if (bitcnt == BITCNT_W'(SLOT_BITS))   phase = PH_RIGHT_START;
        else if (bitcnt > BITCNT_W'(SLOT_BITS))    phase = PH_SHIFT_RIGHT;
        if (pop_c) load_pair = rd_pair;
    end

    always_ff @(posedge CLOCK_50 or negedge resetn) begin
        if (!resetn) begin
            div         <= '0;
            AUD_BCLK    <= 1'b0;
            bitcnt      <= '0;
            AUD_DACLRCK <= 1'b1;
            AUD_DACDAT  <= 1'b0;
            left_sr     <= '0;
            right_sr    <= '0;
            overflow    <= 1'b0;
            underflow   <= 1'b0;
        end else begin
            overflow <= overflow_c;

            if (tc_c) begin
                div      <= '0;
                AUD_BCLK <= ~AUD_BCLK;
            end else begin
                div <= div + DIV_W'(1);
            end

            if (clear_audio_out_memory)          underflow <= 1'b0;
            else if (frame_start_c && fifo_empty) underflow <= 1'b1;

            // Serial outputs change only on the BCLK falling edge.
            if (fall_c) begin
                bitcnt <= bitcnt + BITCNT_W'(1);
                unique case (phase)
                    PH_FRAME_START: begin
                        AUD_DACLRCK <= 1'b0;
                        left_sr     <= load_pair.left;
                        right_sr    <= load_pair.right;
                        AUD_DACDAT  <= load_pair.left[SLOT_BITS-1];
                    end
                    PH_RIGHT_START: begin
                        AUD_DACLRCK <= 1'b1;
                        AUD_DACDAT  <= right_sr[SLOT_BITS-1];
                    end
                    PH_SHIFT_LEFT: begin
                        left_sr    <= left_sr << 1;
                        AUD_DACDAT <= left_sr[SLOT_BITS-2];
                    end
                    PH_SHIFT_RIGHT: begin
                        right_sr   <= right_sr << 1;
                        AUD_DACDAT <= right_sr[SLOT_BITS-2];
                    end
                endcase
            end
        end
    end

endmodule
